// File: rtl/pop_ack_responder.sv
// Responder end of the pop-ack protocol: a DEPTH-entry valid/ready FIFO whose head
// is returned on a one-cycle ack, no earlier than LATENCY cycles after pop rises.
module pop_ack_responder #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     ack,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned LAT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int unsigned LAT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        WAIT,
        ACK
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   lat_cnt_d;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               has_data;
    logic               do_push;
    logic               do_pop;

    assign has_data   = (count != '0);
    assign push_ready = (count != CNT_W'(DEPTH));
    assign do_push    = push_valid & push_ready;
    assign do_pop     = (state == ACK);
    assign ack        = do_pop;

    // State and latency-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_d;
            lat_cnt <= lat_cnt_d;
        end
    end

    // Request sequencing; dropping pop before the ack abandons the request
    always_comb begin
        state_d   = state;
        lat_cnt_d = lat_cnt;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    if (LATENCY == 1) begin
                        state_d = has_data ? ACK : WAIT;
                    end else begin
                        state_d   = DELAY;
                        lat_cnt_d = LAT_W'(LAT_LOAD);
                    end
                end
            end
            DELAY: begin
                if (!pop) begin
                    state_d = IDLE;
                end else if (lat_cnt == '0) begin
                    state_d = has_data ? ACK : WAIT;
                end else begin
                    lat_cnt_d = lat_cnt - LAT_W'(1);
                end
            end
            WAIT: begin
                if (!pop) begin
                    state_d = IDLE;
                end else if (has_data) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage array carries no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Head captured as the ack cycle is entered; held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (state_d == ACK) begin
            rdata <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_pop_ack_responder.sv
// Bench for pop_ack_responder: one LATENCY=1 and one LATENCY=3 instance, checked every
// cycle against a queue-based timing model plus directed literal expectations.
module tb_pop_ack_responder;

    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pv [2];
    logic          pp [2];
    logic [W-1:0]  pd [2];

    logic          ak0, ak1, pr0, pr1;
    logic [W-1:0]  rd0, rd1;
    logic [2:0]    cnt0, cnt1;

    logic [1:0]    ackv;
    logic [1:0]    prv;
    logic [W-1:0]  rdv  [2];
    logic [2:0]    cntv [2];

    int nvec = 0;
    int nmis = 0;

    typedef logic [W-1:0] q_t [$];
    q_t            mq [2];
    bit            m_ack [2];
    bit            m_act [2];
    int            m_start [2];
    logic [W-1:0]  m_rdata [2];
    int            cyc;

    int            ack_cyc [$];
    logic [W-1:0]  ack_dat [$];

    always #5 clk = ~clk;

    pop_ack_responder #(.WIDTH(W), .DEPTH(D), .LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .push_valid(pv[0]), .push_ready(pr0), .push_data(pd[0]),
        .pop(pp[0]), .ack(ak0), .rdata(rd0), .count(cnt0)
    );

    pop_ack_responder #(.WIDTH(W), .DEPTH(D), .LATENCY(3)) dut1 (
        .clk(clk), .rst(rst), .push_valid(pv[1]), .push_ready(pr1), .push_data(pd[1]),
        .pop(pp[1]), .ack(ak1), .rdata(rd1), .count(cnt1)
    );

    always_comb begin
        ackv    = {ak1, ak0};
        prv     = {pr1, pr0};
        rdv[0]  = rd0;
        rdv[1]  = rd1;
        cntv[0] = cnt0;
        cntv[1] = cnt1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: a request starts when pop is high outside an ack cycle; it is acked on the
    // first cycle >= start+LATENCY whose previous cycle saw data, if pop never dropped.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            cyc = 0;
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                m_ack[i]   = 1'b0;
                m_act[i]   = 1'b0;
                m_start[i] = 0;
                m_rdata[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit ack_nxt;
                bit push_ok;
                int lat;
                lat     = (i == 0) ? 1 : 3;
                ack_nxt = 1'b0;
                push_ok = pv[i] && (mq[i].size() < D);
                if (m_ack[i]) begin
                    m_act[i] = 1'b0;
                end else if (!m_act[i] && pp[i]) begin
                    m_act[i]   = 1'b1;
                    m_start[i] = cyc;
                end else if (m_act[i] && !pp[i]) begin
                    m_act[i] = 1'b0;
                end
                if (m_act[i] && (cyc + 1 >= m_start[i] + lat) && mq[i].size() != 0) begin
                    ack_nxt    = 1'b1;
                    m_act[i]   = 1'b0;
                    m_rdata[i] = mq[i][0];
                end
                if (m_ack[i]) void'(mq[i].pop_front());
                if (push_ok) mq[i].push_back(pd[i]);
                m_ack[i] = ack_nxt;
            end
            cyc++;
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d_ack", i), 32'(ackv[i]), 32'(m_ack[i]));
                check($sformatf("d%0d_count", i), 32'(cntv[i]), mq[i].size());
                check($sformatf("d%0d_push_ready", i), 32'(prv[i]), 32'(mq[i].size() != D));
                if (m_ack[i]) check($sformatf("d%0d_rdata", i), rdv[i], m_rdata[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int i, input logic [31:0] exp, input string name);
        bit got;
        got   = 1'b0;
        pp[i] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ackv[i]) begin
                got = 1'b1;
                check({name, "_data"}, rdv[i], exp);
            end
            tick();
        end
        pp[i] = 1'b0;
        check({name, "_acked"}, 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (vectors %0d)", nvec);
        $fatal(1);
    end

    initial begin
        int nxt;
        int got;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0;
            pp[i] = 1'b0;
            pd[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_d%0d_ack", i), 32'(ackv[i]), 32'd0);
            check($sformatf("rst_d%0d_count", i), 32'(cntv[i]), 32'd0);
            check($sformatf("rst_d%0d_ready", i), 32'(prv[i]), 32'd1);
            check($sformatf("rst_d%0d_rdata", i), rdv[i], 32'd0);
        end
        rst = 1'b0;

        // Reset mid-request: dut0 waiting on empty FIFO, dut1 counting down with data
        pp[0] = 1'b1; pv[1] = 1'b1; pd[1] = 32'h55;
        tick();
        pv[1] = 1'b0; pp[1] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t1_pre_count1", 32'(cnt1), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_ack0", 32'(ak0), 32'd0);
        check("t1_async_ack1", 32'(ak1), 32'd0);
        check("t1_async_count1", 32'(cnt1), 32'd0);
        check("t1_async_ready1", 32'(pr1), 32'd1);
        pp[0] = 1'b0; pp[1] = 1'b0;
        tick();
        rst = 1'b0;
        pv[0] = 1'b1; pd[0] = 32'h77;
        tick();
        pv[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t1_no_ack0", 32'(ak0), 32'd0);
            check("t1_no_ack1", 32'(ak1), 32'd0);
            tick();
        end
        request(0, 32'h77, "t1_new_req");

        // Basic LATENCY=1
        pv[0] = 1'b1; pd[0] = 32'hA5;
        tick();
        pv[0] = 1'b0;
        tick();
        pp[0] = 1'b1;
        @(negedge clk);
        check("t2_T_ack", 32'(ak0), 32'd0);
        check("t2_T_count", 32'(cnt0), 32'd1);
        tick();
        @(negedge clk);
        check("t2_T1_ack", 32'(ak0), 32'd1);
        check("t2_T1_rdata", rd0, 32'hA5);
        check("t2_T1_count", 32'(cnt0), 32'd1);
        pp[0] = 1'b0;
        tick();
        @(negedge clk);
        check("t2_T2_ack", 32'(ak0), 32'd0);
        check("t2_T2_count", 32'(cnt0), 32'd0);
        tick();

        // Empty wait, push arrives at cycle 5
        pp[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_wait_ack", 32'(ak0), 32'd0);
            tick();
        end
        pv[0] = 1'b1; pd[0] = 32'h11;
        tick();
        pv[0] = 1'b0;
        @(negedge clk);
        check("t3_T1_ack", 32'(ak0), 32'd0);
        check("t3_T1_count", 32'(cnt0), 32'd1);
        tick();
        @(negedge clk);
        check("t3_T2_ack", 32'(ak0), 32'd1);
        check("t3_T2_rdata", rd0, 32'h11);
        tick();
        pp[0] = 1'b0;
        @(negedge clk);
        check("t3_T3_ack", 32'(ak0), 32'd0);
        check("t3_T3_count", 32'(cnt0), 32'd0);
        tick();

        // Fill to DEPTH, then continuous pop with pushes of 4 and 5
        for (int k = 0; k < 4; k++) begin
            pv[0] = 1'b1; pd[0] = W'(k);
            tick();
        end
        pv[0] = 1'b0;
        @(negedge clk);
        check("t4_full_count", 32'(cnt0), 32'd4);
        check("t4_full_ready", 32'(pr0), 32'd0);
        tick();
        nxt = 4;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            pp[0] = 1'b1;
            pv[0] = (nxt < 6);
            pd[0] = W'(nxt);
            @(negedge clk);
            if (pv[0] && pr0) nxt++;
            if (ak0) begin
                check($sformatf("t4_ack%0d_data", got), rd0, W'(got));
                if (got == 0) begin
                    check("t4_full_ack_ready", 32'(pr0), 32'd0);
                    check("t4_full_ack_count", 32'(cnt0), 32'd4);
                end
                got++;
            end
            tick();
        end
        pp[0] = 1'b0;
        pv[0] = 1'b0;
        check("t4_ack_total", got, 32'd6);
        tick();

        // Back-to-back on LATENCY=3
        pv[1] = 1'b1; pd[1] = 32'h100;
        tick();
        pd[1] = 32'h200;
        tick();
        pd[1] = 32'h300;
        tick();
        pv[1] = 1'b0;
        pp[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ak1) begin
                ack_cyc.push_back(c);
                ack_dat.push_back(rd1);
                if (ack_cyc.size() == 3) pp[1] = 1'b0;
            end
            tick();
        end
        check("t5_ack_total", ack_cyc.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t5_ack%0d_cycle", k),
                  (k < ack_cyc.size()) ? ack_cyc[k] : -1, 32'(3 + 4 * k));
            check($sformatf("t5_ack%0d_data", k),
                  (k < ack_dat.size()) ? ack_dat[k] : '1, 32'(32'h100 * (k + 1)));
        end
        check("t5_count_end", 32'(cnt1), 32'd0);

        // Abort on dut0 (WAIT) and dut1 (DELAY)
        pp[0] = 1'b1; pv[1] = 1'b1; pd[1] = 32'hD00D;
        tick();
        pv[1] = 1'b0; pp[1] = 1'b1;
        tick();
        pp[0] = 1'b0;
        tick();
        pp[1] = 1'b0;
        pv[0] = 1'b1; pd[0] = 32'hC0DE;
        tick();
        pv[0] = 1'b0;
        pv[1] = 1'b1; pd[1] = 32'hE00E;
        tick();
        pv[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_no_ack0", 32'(ak0), 32'd0);
            check("t6_no_ack1", 32'(ak1), 32'd0);
            tick();
        end
        check("t6_count0", 32'(cnt0), 32'd1);
        check("t6_count1", 32'(cnt1), 32'd2);
        request(0, 32'hC0DE, "t6_d0_req");
        request(1, 32'hD00D, "t6_d1_head");
        request(1, 32'hE00E, "t6_d1_next");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
